// File: rtl/conv_seq_controller.sv
// Convolution pass sequencer: walks taps, output positions, filters and rows
// with internal counters; start/busy/done handshake, cfg checking, backpressure, abort.
module conv_seq_controller #(
  parameter int CNT_W       = 8,
  parameter int NUM_FILTERS = 4,
  parameter int FW          = $clog2(NUM_FILTERS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_stride,
  input  logic [CNT_W-1:0] cfg_filter_len,
  input  logic [CNT_W-1:0] cfg_row_outputs,
  input  logic [CNT_W-1:0] cfg_num_rows,
  input  logic [FW-1:0]    cfg_num_filters,
  input  logic             av_data,
  input  logic             av_filter,
  input  logic             out_full,
  output logic             ld_stride,
  output logic             ld_filter_size,
  output logic             put_data,
  output logic             put_filter,
  output logic             clear_sum,
  output logic             store_buffer,
  output logic             next_filter,
  output logic             next_row,
  output logic [FW-1:0]    filter_sel,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_COMMIT, S_DONE, S_ERR
  } state_t;

  localparam logic [FW-1:0]    NF_MAX = FW'(NUM_FILTERS);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [FW-1:0]    F_ONE  = FW'(1);

  state_t state, state_nx;

  logic [CNT_W-1:0] len_q, rout_q, rows_q;
  logic [FW-1:0]    nfilt_q;
  logic [CNT_W-1:0] tap_q, pos_q, row_q;
  logic [CNT_W-1:0] tap_nx, pos_nx, row_nx;
  logic [FW-1:0]    filt_q, filt_nx;
  logic             cfg_bad, fire;
  logic             last_tap, last_pos, last_filt, last_row;

  assign cfg_bad = (cfg_stride == '0) || (cfg_filter_len == '0) ||
                   (cfg_row_outputs == '0) || (cfg_num_rows == '0) ||
                   (cfg_num_filters == '0) || (cfg_num_filters > NF_MAX);

  assign fire      = av_data & av_filter;
  assign last_tap  = (tap_q  == len_q   - C_ONE);
  assign last_pos  = (pos_q  == rout_q  - C_ONE);
  assign last_filt = (filt_q == nfilt_q - F_ONE);
  assign last_row  = (row_q  == rows_q  - C_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      tap_q  <= '0;
      pos_q  <= '0;
      filt_q <= '0;
      row_q  <= '0;
    end else begin
      state  <= state_nx;
      tap_q  <= tap_nx;
      pos_q  <= pos_nx;
      filt_q <= filt_nx;
      row_q  <= row_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= '0;
      rout_q  <= '0;
      rows_q  <= '0;
      nfilt_q <= '0;
    end else if (state == S_LOAD) begin
      len_q   <= cfg_filter_len;
      rout_q  <= cfg_row_outputs;
      rows_q  <= cfg_num_rows;
      nfilt_q <= cfg_num_filters;
    end
  end

  always_comb begin
    state_nx       = state;
    tap_nx         = tap_q;
    pos_nx         = pos_q;
    filt_nx        = filt_q;
    row_nx         = row_q;
    ld_stride      = 1'b0;
    ld_filter_size = 1'b0;
    put_data       = 1'b0;
    put_filter     = 1'b0;
    clear_sum      = 1'b0;
    store_buffer   = 1'b0;
    next_filter    = 1'b0;
    next_row       = 1'b0;
    done           = 1'b0;
    cfg_err        = 1'b0;

    case (state)
      S_IDLE: if (start) state_nx = cfg_bad ? S_ERR : S_LOAD;
      S_LOAD: begin
        ld_stride      = 1'b1;
        ld_filter_size = 1'b1;
        tap_nx         = '0;
        pos_nx         = '0;
        filt_nx        = '0;
        row_nx         = '0;
        state_nx       = S_RUN;
      end
      S_RUN: begin
        put_data   = fire;
        put_filter = fire;
        if (fire) begin
          if (last_tap) begin
            tap_nx   = '0;
            state_nx = S_COMMIT;
          end else begin
            tap_nx = tap_q + C_ONE;
          end
        end
      end
      S_COMMIT: if (!out_full) begin
        store_buffer = 1'b1;
        clear_sum    = 1'b1;
        state_nx     = S_RUN;
        // position -> filter -> row carry chain; the final carry ends the pass
        if (!last_pos) begin
          pos_nx = pos_q + C_ONE;
        end else begin
          pos_nx      = '0;
          next_filter = 1'b1;
          if (!last_filt) begin
            filt_nx = filt_q + F_ONE;
          end else begin
            filt_nx  = '0;
            next_row = 1'b1;
            if (!last_row) begin
              row_nx = row_q + C_ONE;
            end else begin
              row_nx   = '0;
              state_nx = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        cfg_err  = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase

    if (abort && (state != S_IDLE)) begin
      ld_stride      = 1'b0;
      ld_filter_size = 1'b0;
      put_data       = 1'b0;
      put_filter     = 1'b0;
      clear_sum      = 1'b0;
      store_buffer   = 1'b0;
      next_filter    = 1'b0;
      next_row       = 1'b0;
      done           = 1'b0;
      cfg_err        = 1'b0;
      state_nx       = S_IDLE;
      tap_nx         = '0;
      pos_nx         = '0;
      filt_nx        = '0;
      row_nx         = '0;
    end
  end

  assign busy       = (state != S_IDLE);
  assign filter_sel = filt_q;

endmodule

// File: tb/tb_conv_seq_controller.sv
// Self-checking bench for conv_seq_controller: directed scenarios plus randomized
// passes checked against an ordered expected-event list built from the loop nest.
module tb_conv_seq_controller;

  localparam int CNT_W       = 8;
  localparam int NUM_FILTERS = 4;
  localparam int FW          = $clog2(NUM_FILTERS + 1);
  localparam int MAXC        = 256;
  localparam int VW          = 11 + FW;

  localparam int B_LDS = 10 + FW, B_LDF = 9 + FW, B_PD = 8 + FW, B_PF = 7 + FW;
  localparam int B_CLR = 6 + FW, B_ST = 5 + FW, B_NF = 4 + FW, B_NR = 3 + FW;
  localparam int B_BUSY = 2 + FW, B_DONE = 1 + FW, B_ERR = FW;

  localparam int K_NONE = 0, K_LD = 1, K_PUT = 2, K_STORE = 3, K_DONE = 4;

  logic             clk, rst_n, start, abort;
  logic [CNT_W-1:0] cfg_stride, cfg_filter_len, cfg_row_outputs, cfg_num_rows;
  logic [FW-1:0]    cfg_num_filters;
  logic             av_data, av_filter, out_full;
  logic             ld_stride, ld_filter_size, put_data, put_filter, clear_sum;
  logic             store_buffer, next_filter, next_row, busy, done, cfg_err;
  logic [FW-1:0]    filter_sel;

  int checks = 0;
  int errors = 0;
  int done_cyc;
  logic [VW-1:0] rec [MAXC];

  conv_seq_controller #(.CNT_W(CNT_W), .NUM_FILTERS(NUM_FILTERS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .cfg_stride(cfg_stride), .cfg_filter_len(cfg_filter_len),
    .cfg_row_outputs(cfg_row_outputs), .cfg_num_rows(cfg_num_rows),
    .cfg_num_filters(cfg_num_filters), .av_data(av_data), .av_filter(av_filter),
    .out_full(out_full), .ld_stride(ld_stride), .ld_filter_size(ld_filter_size),
    .put_data(put_data), .put_filter(put_filter), .clear_sum(clear_sum),
    .store_buffer(store_buffer), .next_filter(next_filter), .next_row(next_row),
    .filter_sel(filter_sel), .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [VW-1:0] outs();
    return {ld_stride, ld_filter_size, put_data, put_filter, clear_sum, store_buffer,
            next_filter, next_row, busy, done, cfg_err, filter_sel};
  endfunction

  // Expected output vector for one cycle carrying the given event.
  function automatic logic [VW-1:0] ev(input int kind, input int fsel, input bit nf,
                                       input bit nr, input bit bsy);
    logic [VW-1:0] v;
    v = '0;
    case (kind)
      K_LD:    begin v[B_LDS] = 1'b1; v[B_LDF] = 1'b1; end
      K_PUT:   begin v[B_PD] = 1'b1; v[B_PF] = 1'b1; end
      K_STORE: begin v[B_CLR] = 1'b1; v[B_ST] = 1'b1; v[B_NF] = nf; v[B_NR] = nr; end
      K_DONE:  v[B_DONE] = 1'b1;
      default: ;
    endcase
    v[B_BUSY] = bsy;
    v[FW-1:0] = FW'(fsel);
    return v;
  endfunction

  function automatic int count_bit(input int b, input int upto);
    int n = 0;
    for (int c = 0; c <= upto && c < MAXC; c++) if (rec[c][b] === 1'b1) n++;
    return n;
  endfunction

  // filter_sel at each store, one nibble per store, oldest in the high nibble
  function automatic logic [31:0] store_seq(input int upto);
    logic [31:0] s = '0;
    for (int c = 0; c <= upto && c < MAXC; c++)
      if (rec[c][B_ST] === 1'b1) s = {s[27:0], 4'(rec[c][FW-1:0])};
    return s;
  endfunction

  function automatic logic [31:0] model_seq(input int rows, input int nf, input int ro);
    logic [31:0] s = '0;
    for (int r = 0; r < rows; r++)
      for (int f = 0; f < nf; f++)
        for (int p = 0; p < ro; p++) s = {s[27:0], 4'(f)};
    return s;
  endfunction

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int len, input int ro, input int rows, input int nf);
    cfg_stride      = CNT_W'($urandom_range(1, 255));
    cfg_filter_len  = CNT_W'(len);
    cfg_row_outputs = CNT_W'(ro);
    cfg_num_rows    = CNT_W'(rows);
    cfg_num_filters = FW'(nf);
  endtask

  task automatic scramble_cfg();
    cfg_stride      = CNT_W'($urandom);
    cfg_filter_len  = CNT_W'($urandom);
    cfg_row_outputs = CNT_W'($urandom);
    cfg_num_rows    = CNT_W'($urandom);
    cfg_num_filters = FW'($urandom);
  endtask

  // Cycle 0 carries the start pulse; records outputs per cycle until done.
  task automatic run_pass(input int limit, input int avl_from, input int avl_len,
                          input int full_from, input int full_len, input int abort_at,
                          input bit start_hold, input bit scramble);
    for (int c = 0; c < MAXC; c++) rec[c] = '0;
    done_cyc = -1;
    for (int c = 0; c < limit; c++) begin
      start     = (c == 0) || start_hold;
      abort     = (c == abort_at);
      av_data   = 1'b1;
      av_filter = !(c >= avl_from && c < avl_from + avl_len);
      out_full  = (c >= full_from && c < full_from + full_len);
      if (scramble && c >= 2) scramble_cfg();
      @(negedge clk);
      rec[c] = outs();
      align();
      if (rec[c][B_DONE] === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    start = 1'b0; abort = 1'b0; out_full = 1'b0; av_filter = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; av_data = 1'b1; av_filter = 1'b1;
    #17;
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", outs(), {VW{1'b0}});
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin
      errors++; $display("FAIL reset_idle: got %b want %b", outs(), {VW{1'b0}});
    end
    align();
  endtask

  task automatic test_minimal();
    int kinds [6] = '{K_NONE, K_LD, K_PUT, K_PUT, K_STORE, K_DONE};
    logic [VW-1:0] exp;
    set_cfg(2, 1, 1, 1);
    run_pass(20, -1, 0, -1, 0, -1, 1'b0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      exp = ev(kinds[c], 0, 1'b1, 1'b1, c != 0);
      checks++;
      if (rec[c] !== exp) begin
        errors++; $display("FAIL minimal_c%0d: got %b want %b", c, rec[c], exp);
      end
    end
    checks++;
    if (done_cyc != 5) begin errors++; $display("FAIL minimal_done: got %0d want 5", done_cyc); end
    @(negedge clk);
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL minimal_idle: got %b want 0", outs()); end
    align();
  endtask

  task automatic test_full_loop(input bit start_hold, input bit scramble);
    int exp_done = 2 + 2 * 2 * 2 * (3 + 1);
    set_cfg(3, 2, 2, 2);
    run_pass(60, -1, 0, -1, 0, -1, start_hold, scramble);
    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL loop_done h%0d: got %0d want %0d", start_hold, done_cyc, exp_done);
    end
    checks++;
    if (count_bit(B_PD, done_cyc) != 24 || count_bit(B_PF, done_cyc) != 24) begin
      errors++; $display("FAIL loop_puts: got %0d/%0d want 24", count_bit(B_PD, done_cyc),
                         count_bit(B_PF, done_cyc));
    end
    checks++;
    if (count_bit(B_ST, done_cyc) != 8 || count_bit(B_CLR, done_cyc) != 8) begin
      errors++; $display("FAIL loop_stores: got %0d/%0d want 8", count_bit(B_ST, done_cyc),
                         count_bit(B_CLR, done_cyc));
    end
    checks++;
    if (count_bit(B_NF, done_cyc) != 4 || count_bit(B_NR, done_cyc) != 2) begin
      errors++; $display("FAIL loop_next: got nf=%0d nr=%0d want nf=4 nr=2",
                         count_bit(B_NF, done_cyc), count_bit(B_NR, done_cyc));
    end
    checks++;
    if (count_bit(B_LDS, done_cyc) != 1) begin
      errors++; $display("FAIL loop_ld: got %0d want 1", count_bit(B_LDS, done_cyc));
    end
    checks++;
    if (store_seq(done_cyc) !== model_seq(2, 2, 2)) begin
      errors++; $display("FAIL loop_fsel: got %h want %h", store_seq(done_cyc), model_seq(2, 2, 2));
    end
  endtask

  task automatic test_stall();
    set_cfg(2, 1, 1, 1);
    run_pass(30, 3, 3, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (count_bit(B_PD, done_cyc) != 2 || rec[3][B_PD] || rec[4][B_PD] || rec[5][B_PD]
        || !rec[6][B_PD]) begin
      errors++; $display("FAIL stall_puts: got cnt=%0d c3..6=%b%b%b%b want 2,0001",
                         count_bit(B_PD, done_cyc), rec[3][B_PD], rec[4][B_PD], rec[5][B_PD],
                         rec[6][B_PD]);
    end
    checks++;
    if (rec[7][B_ST] !== 1'b1) begin errors++; $display("FAIL stall_store: got 0 want 1 at c7"); end
    checks++;
    if (done_cyc != 8) begin errors++; $display("FAIL stall_done: got %0d want 8", done_cyc); end
  endtask

  task automatic test_backpressure();
    set_cfg(2, 1, 1, 1);
    run_pass(30, -1, 0, 4, 5, -1, 1'b0, 1'b0);
    checks++;
    if (count_bit(B_ST, 8) != 0 || rec[9][B_ST] !== 1'b1) begin
      errors++; $display("FAIL bp_store: got early=%0d c9=%b want 0,1", count_bit(B_ST, 8), rec[9][B_ST]);
    end
    checks++;
    if (count_bit(B_PD, done_cyc) != 2 || count_bit(B_PF, done_cyc) != 2) begin
      errors++; $display("FAIL bp_puts: got %0d want 2", count_bit(B_PD, done_cyc));
    end
    checks++;
    if (done_cyc != 10) begin errors++; $display("FAIL bp_done: got %0d want 10", done_cyc); end
  endtask

  task automatic test_cfg_err();
    logic [VW-1:0] exp;
    for (int i = 0; i < 6; i++) begin
      set_cfg(2, 1, 1, 1);
      case (i)
        0: cfg_filter_len = '0;
        1: cfg_row_outputs = '0;
        2: cfg_num_rows = '0;
        3: cfg_stride = '0;
        4: cfg_num_filters = '0;
        default: cfg_num_filters = FW'(NUM_FILTERS + 1);
      endcase
      start = 1'b1;
      align();
      start = 1'b0;
      @(negedge clk);
      exp = '0; exp[B_BUSY] = 1'b1; exp[B_ERR] = 1'b1;
      checks++;
      if (outs() !== exp) begin errors++; $display("FAIL cfgerr%0d_pulse: got %b want %b", i, outs(), exp); end
      align();
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL cfgerr%0d_idle: got %b want 0", i, outs()); end
      align();
    end
  endtask

  task automatic test_abort();
    logic [VW-1:0] exp;
    set_cfg(3, 2, 2, 2);
    run_pass(40, -1, 0, -1, 0, 9, 1'b0, 1'b0);
    exp = ev(K_NONE, 0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (rec[9] !== exp) begin errors++; $display("FAIL abort_commit: got %b want %b", rec[9], exp); end
    checks++;
    if (rec[10] !== '0) begin errors++; $display("FAIL abort_idle: got %b want 0", rec[10]); end
    checks++;
    if (done_cyc != -1) begin errors++; $display("FAIL abort_nodone: got %0d want -1", done_cyc); end
    test_full_loop(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    set_cfg(3, 2, 2, 2);
    av_data = 1'b1; av_filter = 1'b1; start = 1'b1;
    align();
    start = 1'b0;
    align();
    align();
    #2;
    checks++;
    if (put_data !== 1'b1) begin errors++; $display("FAIL rstmid_running: got %b want 1", put_data); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== '0) begin errors++; $display("FAIL rstmid_outputs: got %b want 0", outs()); end
    @(negedge clk);
    rst_n = 1'b1;
    align();
    test_full_loop(1'b0, 1'b0);
  endtask

  task automatic test_random();
    int ek[$]; int ef[$]; bit enf[$]; bit enr[$];
    int len, ro, rows, nf, k, cyc;
    bit ready, bad;
    logic [VW-1:0] exp;
    for (int p = 0; p < 20; p++) begin
      len = $urandom_range(1, 4); ro = $urandom_range(1, 3);
      rows = $urandom_range(1, 3); nf = $urandom_range(1, NUM_FILTERS);
      ek.delete(); ef.delete(); enf.delete(); enr.delete();
      ek.push_back(K_LD); ef.push_back(0); enf.push_back(0); enr.push_back(0);
      for (int r = 0; r < rows; r++)
        for (int f = 0; f < nf; f++)
          for (int q = 0; q < ro; q++) begin
            for (int t = 0; t < len; t++) begin
              ek.push_back(K_PUT); ef.push_back(f); enf.push_back(0); enr.push_back(0);
            end
            ek.push_back(K_STORE); ef.push_back(f);
            enf.push_back(q == ro - 1); enr.push_back(q == ro - 1 && f == nf - 1);
          end
      ek.push_back(K_DONE); ef.push_back(0); enf.push_back(0); enr.push_back(0);

      set_cfg(len, ro, rows, nf);
      start = 1'b1; av_data = 1'($urandom); av_filter = 1'($urandom); out_full = 1'($urandom);
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL rnd%0d_start: got %b want 0", p, outs()); end
      align();
      start = 1'b0;
      k = 0; cyc = 1; bad = 1'b0;
      while (k < ek.size() && cyc < 3000 && !bad) begin
        av_data   = ($urandom_range(0, 3) != 0);
        av_filter = ($urandom_range(0, 3) != 0);
        out_full  = ($urandom_range(0, 3) == 0);
        if (cyc >= 2) scramble_cfg();
        @(negedge clk);
        case (ek[k])
          K_PUT:   ready = av_data && av_filter;
          K_STORE: ready = !out_full;
          default: ready = 1'b1;
        endcase
        exp = ready ? ev(ek[k], ef[k], enf[k], enr[k], 1'b1) : ev(K_NONE, ef[k], 1'b0, 1'b0, 1'b1);
        checks++;
        if (outs() !== exp) begin
          errors++; bad = 1'b1;
          $display("FAIL rnd%0d_c%0d event %0d: got %b want %b", p, cyc, k, outs(), exp);
        end
        if (ready) k++;
        align();
        cyc++;
      end
      checks++;
      if (k != ek.size()) begin
        errors++; $display("FAIL rnd%0d_complete: got %0d events want %0d", p, k, ek.size());
      end
      out_full = 1'b0;
      if (bad || k != ek.size()) begin
        abort = 1'b1; align(); abort = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (outs() !== '0) begin errors++; $display("FAIL rnd%0d_idle: got %b want 0", p, outs()); end
      align();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    av_data = 1'b0; av_filter = 1'b0; out_full = 1'b0;
    set_cfg(2, 1, 1, 1);
    test_reset();
    test_minimal();
    test_full_loop(1'b0, 1'b0);
    test_stall();
    test_backpressure();
    test_cfg_err();
    test_abort();
    test_full_loop(1'b1, 1'b1);
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_seq_controller.md
Name: conv_seq_controller

Overview:
- Parametrised successor to the convolution main controller.
- Sequences a complete multi-filter convolution pass itself, using internal tap, position, filter and row counters. It no longer relies on external end-of-row / end-of-filter flags.
- Adds a start/busy/done handshake, configuration checking, output-buffer backpressure, abort, and a filter-select index.
- Sits between the top-level host interface and the data/filter buffers, MAC and output buffer of the accelerator datapath.

Parameters:
- CNT_W, 8, width of the cfg_stride, cfg_filter_len, cfg_row_outputs and cfg_num_rows inputs and of their internal counters.
- NUM_FILTERS, 4, maximum number of filters supported in one pass.
- FW, $clog2(NUM_FILTERS+1), width of cfg_num_filters and filter_sel (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  start request, sampled in IDLE only.
- abort  in  1  synchronous abort; returns the controller to IDLE.
- cfg_stride  in  CNT_W  stride value; forwarded to the datapath via ld_stride.
- cfg_filter_len  in  CNT_W  taps (MAC cycles) per output.
- cfg_row_outputs  in  CNT_W  outputs per row per filter.
- cfg_num_rows  in  CNT_W  rows per pass.
- cfg_num_filters  in  FW  filters per pass.
- av_data  in  1  data buffer has a valid element.
- av_filter  in  1  filter buffer has a valid element.
- out_full  in  1  output buffer cannot accept a write.
- ld_stride, ld_filter_size  out  1  configuration load strobes.
- put_data, put_filter  out  1  consume one data element and one filter element.
- clear_sum  out  1  clear the accumulator.
- store_buffer  out  1  write the accumulator to the output buffer.
- next_filter  out  1  advance to the next filter.
- next_row  out  1  advance to the next row.
- filter_sel  out  FW  index of the active filter.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.
- cfg_err  out  1  one-cycle pulse when a configuration is rejected.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE and all counters=0, so every output is 0 and filter_sel=0.
- States: IDLE, LOAD, RUN, COMMIT, DONE, ERR.
- IDLE:
  - start=1 with any cfg field equal to 0, or cfg_num_filters>NUM_FILTERS -> ERR.
  - start=1 with a valid configuration -> LOAD.
  - start is ignored in every other state.
- ERR: cfg_err=1 for one cycle -> IDLE.
- LOAD:
  - ld_stride=ld_filter_size=1 for one cycle.
  - All cfg fields are registered internally; cfg inputs are don't-care after this cycle.
  - Tap, position, filter and row counters are cleared -> RUN.
- RUN:
  - fire = av_data & av_filter; put_data=put_filter=fire (combinational, same cycle).
  - Tap counter increments on each fire.
  - A fire with tap==filter_len-1 resets tap to 0 and moves to COMMIT.
  - No fire -> stay in RUN; all strobes are 0.
- COMMIT:
  - While out_full=1: hold, all strobes 0 (no put_*, so no data is lost).
  - When out_full=0: store_buffer=clear_sum=1 for one cycle, then the position/filter/row update below.
- COMMIT position/filter/row update (out_full=0):
  - pos<row_outputs-1: pos+1 -> RUN.
  - pos==row_outputs-1, filter not last: pos=0, next_filter=1, filter_sel+1 -> RUN.
  - pos==row_outputs-1, filter==num_filters-1, row not last: next_filter=1 and next_row=1 in the same cycle; filter_sel=0, row+1 -> RUN.
  - Row is also last: next_filter=next_row=1 -> DONE.
- DONE: done=1 for one cycle, busy=1 -> IDLE.
- abort=1 in any non-IDLE state:
  - All strobes forced to 0 that cycle.
  - Next state IDLE, counters cleared, no done pulse.
  - abort has priority over every other transition.
- Throughput and latency:
  - One output per filter_len+1 cycles when av_* are held high and out_full=0.
  - Minimum pass length from the start cycle to the done pulse: 2 + rows*filters*row_outputs*(filter_len+1) cycles.
- Counter comparisons are against the registered configuration; no counter wraps except through the explicit resets above.
- put_* are never asserted outside RUN.
- store_buffer and clear_sum are always asserted together.

Test Plan:
- Reset mid-RUN: drop rst_n asynchronously -> all outputs 0 immediately; busy=0; the next start begins a fresh pass.
- Minimal pass: cfg len=2, row_out=1, rows=1, filters=1, av_* held high, start pulse -> ld_* high at cycle 1; put_* high at cycles 2-3; store_buffer, next_filter and next_row high at cycle 4; done at cycle 5.
- Full loop: len=3, row_out=2, rows=2, filters=2:
  - exactly 8 store_buffer pulses and 24 put_data pulses;
  - filter_sel sequence 0,0,1,1,0,0,1,1;
  - next_row pulses = 2, next_filter pulses = 4;
  - done after 2+8*4=34 cycles.
- Stall and backpressure, using the minimal pass configuration:
  - Toggle av_filter low for 3 cycles during RUN -> put_* suppressed and the pass is delayed by 3 cycles.
  - Hold out_full high for 5 cycles in COMMIT -> store_buffer is delayed 5 cycles and no put_* occurs meanwhile.
- Config error: cfg_filter_len=0 or cfg_num_filters=NUM_FILTERS+1 -> cfg_err pulse 1 cycle after start; no ld_*; back in IDLE with busy=0.
- Abort and ignored start:
  - Assert abort in COMMIT with out_full=0 -> no store_buffer that cycle; next cycle busy=0 and no done pulse.
  - A start during busy has no effect on counters or outputs.
